// File: rtl/aidan_mcnay_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : aidan_mcnay_down_counter
// Description : Emits an inclusive descending sequence start_val..stop_val on a
//               valid/ready output port, pulses done on normal completion and
//               supports abort. Every output is a register.
// Revision    : 1.0 - initial release
// ============================================================================
module aidan_mcnay_down_counter #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [nbits-1:0] start_val,
  input  logic [nbits-1:0] stop_val,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_val,
  output logic [nbits-1:0] out_num,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [nbits-1:0] counter;
  logic [nbits-1:0] floor_val;
  logic             transfer;
  logic             at_floor;

  // A value leaves the block whenever the registered valid meets ready.
  assign transfer = out_val & out_ready;
  // Comparing against the stored floor (never wrapping) ends the sequence.
  assign at_floor = (counter == floor_val);

  // Control FSM with registered outputs; out_num keeps its value outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      floor_val <= '0;
      out_val   <= 1'b0;
      out_num   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            counter   <= start_val;
            floor_val <= stop_val;
            if (start_val >= stop_val) begin
              state   <= RUN;
              out_val <= 1'b1;
              busy    <= 1'b1;
              out_num <= start_val;
            end else begin
              // Empty range: go straight to the completion pulse.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          // A transfer in the abort cycle still completes, so decrement first.
          if (transfer && !at_floor) begin
            counter <= counter - 1'b1;
            out_num <= counter - 1'b1;
          end
          if (abort) begin
            state   <= IDLE;
            out_val <= 1'b0;
            busy    <= 1'b0;
          end else if (transfer && at_floor) begin
            state   <= DONE;
            out_val <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          out_val <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aidan_mcnay_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aidan_mcnay_down_counter
// Description : Self-checking bench; a queue-based sequence model predicts
//               every output on every cycle, plus directed sequence checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aidan_mcnay_down_counter;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NB-1:0] start_val;
  logic [NB-1:0] stop_val;
  logic          abort;
  logic          out_ready;
  logic          out_val;
  logic [NB-1:0] out_num;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  // Model: 0 = idle, 1 = emitting, 2 = completion pulse.
  int m_mode = 0;
  int m_num  = 0;
  int m_q[$];
  int got_q[$];
  int exp_q[$];
  int done_seen = 0;

  aidan_mcnay_down_counter #(.nbits(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_val (start_val),
    .stop_val  (stop_val),
    .abort     (abort),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_num   (out_num),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_val"},  {31'd0, out_val}, (m_mode == 1) ? 32'd1 : 32'd0);
    check({tag, "_busy"}, {31'd0, busy},    (m_mode == 1) ? 32'd1 : 32'd0);
    check({tag, "_done"}, {31'd0, done},    (m_mode == 2) ? 32'd1 : 32'd0);
    check({tag, "_num"},  {24'd0, out_num}, m_num);
  endtask

  // One clock: inputs are already driven; predict, clock, then compare.
  task automatic step();
    int nm;
    int nn;
    int sv;
    int pv;
    nm = m_mode;
    nn = m_num;
    sv = int'(start_val);
    pv = int'(stop_val);
    if (out_val && out_ready) got_q.push_back(int'(out_num));
    if (m_mode == 0) begin
      if (start) begin
        if (sv >= pv) begin
          m_q.delete();
          for (int v = sv; v >= pv; v--) m_q.push_back(v);
          nm = 1;
          nn = sv;
        end else begin
          nm = 2;
        end
      end
    end else if (m_mode == 1) begin
      if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() > 0) nn = m_q[0];
      end
      if (abort) nm = 0;
      else if (m_q.size() == 0) nm = 2;
    end else begin
      nm = 0;
    end
    @(posedge clk);
    m_mode = nm;
    m_num  = nn;
    @(negedge clk);
    if (done) done_seen++;
    check_outputs("cyc");
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (m_mode != 0 && n < budget) begin
      step();
      n++;
    end
    check("reach_idle", {31'd0, busy}, 32'd0);
    check("idle_budget", (m_mode == 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic begin_seq(input int sv, input int pv);
    got_q.delete();
    done_seen = 0;
    start     = 1'b1;
    start_val = NB'(sv);
    stop_val  = NB'(pv);
    out_ready = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_list(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_item"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    int pat[7];
    rst_n = 1'b0; start = 1'b0; start_val = '0; stop_val = '0;
    abort = 1'b0; out_ready = 1'b0;
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic countdown 5..2 at full throughput.
    begin_seq(5, 2);
    run_idle(20);
    exp_q = '{5, 4, 3, 2};
    check_list("basic");
    check("basic_done_cnt", done_seen, 1);

    // Backpressure 3..0.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    begin_seq(3, 0);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i][0];
      step();
    end
    run_idle(20);
    exp_q = '{3, 2, 1, 0};
    check_list("bp");
    check("bp_done_cnt", done_seen, 1);

    // Single value range.
    begin_seq(7, 7);
    run_idle(10);
    exp_q = '{7};
    check_list("single");
    check("single_done_cnt", done_seen, 1);

    // Empty range: done directly after start.
    begin_seq(1, 4);
    check("empty_done_now", {31'd0, done}, 32'd1);
    check("empty_no_val", {31'd0, out_val}, 32'd0);
    run_idle(10);
    check("empty_len", got_q.size(), 0);

    // Abort on the third transfer cycle.
    begin_seq(10, 0);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    exp_q = '{10, 9, 8};
    check_list("abort");
    check("abort_no_done", done_seen, 0);

    // Start while busy is ignored.
    begin_seq(6, 3);
    step();
    start = 1'b1; start_val = NB'(99); stop_val = '0;
    step();
    start = 1'b0;
    run_idle(20);
    exp_q = '{6, 5, 4, 3};
    check_list("busy_start");

    // Full range 255..0.
    begin_seq(255, 0);
    run_idle(300);
    check("full_len", got_q.size(), 256);
    check("full_first", got_q[0], 255);
    check("full_last", got_q[got_q.size()-1], 0);

    // Asynchronous reset mid-run.
    begin_seq(20, 0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    m_mode = 0; m_num = 0; m_q.delete();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    begin_seq(2, 1);
    run_idle(10);
    exp_q = '{2, 1};
    check_list("post_rst");
    check("post_rst_done", done_seen, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      start_val = NB'($urandom_range(0, 15));
      stop_val  = NB'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 1) == 1;
      abort     = ($urandom_range(0, 9) == 0);
      step();
    end
    start = 1'b0; abort = 1'b0;
    run_idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
